clk_div_multi: RTL and testbench

Multi-channel programmable clock-enable divider, the parametrised successor to the single fixed divider in `rtl_topmodule`. It derives NCH independent divided strobes or square waves from the one system clock. Each channel has a runtime-programmable ratio and mode. Ratio changes go through a valid/ready config port and are applied glitch-free at the channel's terminal count. Outputs are enables or data-rate waveforms in the `clk` domain; they are never used as gated clocks.

---
 rtl/clk_div_pkg.sv | 28 ++
 rtl/clk_div_chan.sv | 99 +++++++++
 rtl/clk_div_multi.sv | 70 +++++++
 tb/tb_clk_div_multi.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock-enable divider.
package clk_div_pkg;

    // Widest divide ratio any channel can be built with; config structs carry
    // the ratio zero-extended to this width.
    localparam int DIV_W_MAX = 16;

    typedef enum logic {
        STROBE = 1'b0,
        SQUARE = 1'b1
    } div_mode_e;

    typedef enum logic {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } chan_state_e;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] div;
        div_mode_e            mode;
    } div_cfg_t;

    // ceil(n/2): number of high cycles of a SQUARE period of length n.
    function automatic logic [DIV_W_MAX-1:0] ceil_half(input logic [DIV_W_MAX-1:0] n);
        return (n >> 1) + {{(DIV_W_MAX-1){1'b0}}, n[0]};
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending config and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 9,
    parameter int DIV_RST = 0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_i,
    input  div_cfg_t cfg_i,
    input  logic     sync_i,
    output logic     pend_o,
    output logic     div_o,
    output logic     tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    div_cfg_t         act_q, act_d;
    div_cfg_t         pcfg_q, pcfg_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    chan_state_e      state;
    logic             boundary;
    logic             run_d;

    // Next-state: every period boundary (sync, wrap, or idle while stopped)
    // restarts the count and loads the freshest config; otherwise a write parks.
    always_comb begin
        act_d    = act_q;
        pcfg_d   = pcfg_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        state    = (act_q.div == '0) ? STOPPED : RUN;
        boundary = sync_i || (state == STOPPED) ||
                   (DIV_W_MAX'(cnt_q) == act_q.div - DIV_W_MAX'(1));
        if (boundary) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (wr_i) begin
                act_d = cfg_i;
            end else if (pend_q) begin
                act_d = pcfg_q;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (wr_i) begin
                pcfg_d = cfg_i;
                pend_d = 1'b1;
            end
        end
    end

    // Outputs are derived from the next-state count so they line up with it.
    always_comb begin
        run_d  = (act_d.div != '0);
        tick_d = run_d && (DIV_W_MAX'(cnt_d) == act_d.div - DIV_W_MAX'(1));
        div_d  = 1'b0;
        if (run_d) begin
            if (act_d.mode == SQUARE) begin
                div_d = (DIV_W_MAX'(cnt_d) < ceil_half(act_d.div));
            end else begin
                div_d = tick_d;
            end
        end
    end

    // Counter and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            act_q  <= '{div: DIV_W_MAX'(DIV_RST), mode: STROBE};
            pcfg_q <= '{div: '0, mode: STROBE};
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pcfg_q <= pcfg_d;
            pend_q <= pend_d;
        end
    end

    // Output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign pend_o = pend_q;
    assign div_o  = div_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider: config decode and channel array.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DIV_W   = 9,
    parameter int DIV_RST = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                         cfg_div,
    input  logic                                     cfg_mode,
    input  logic                                     sync,
    output logic [NCH-1:0]                           div_o,
    output logic [NCH-1:0]                           tick_o
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    if (NCH < 1 || NCH > 16 || DIV_W < 1 || DIV_W > DIV_W_MAX) begin : g_param_err
        $error("clk_div_multi: NCH must be 1..16 and DIV_W 1..%0d", DIV_W_MAX);
    end

    div_cfg_t       cfg_in;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr;

    // Zero-extend the request into the shared config record.
    always_comb begin
        cfg_in = '{div: DIV_W_MAX'(cfg_div), mode: div_mode_e'(cfg_mode)};
    end

    // Ready mux; an unmapped channel index always reads ready and is ignored.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    // Per-channel write strobe on an accepted transfer.
    always_comb begin
        wr = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr[i] = cfg_valid && ~pend[i] && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .wr_i   (wr[g]),
            .cfg_i  (cfg_in),
            .sync_i (sync),
            .pend_o (pend[g]),
            .div_o  (div_o[g]),
            .tick_o (tick_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi with a behavioural channel model.
module tb_clk_div_multi;

    localparam int NCH   = 3;
    localparam int DIV_W = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_mode;
    logic             sync;
    logic [NCH-1:0]   div_o;
    logic [NCH-1:0]   tick_o;

    int total = 0;
    int bad   = 0;

    clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W), .DIV_RST(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .sync      (sync),
        .div_o     (div_o),
        .tick_o    (tick_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference model: ratio, mode, position in period, parked update.
    int unsigned m_n[NCH], m_cnt[NCH], m_pn[NCH];
    bit          m_sq[NCH], m_psq[NCH], m_pv[NCH];

    function automatic bit m_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !m_pv[cfg_ch];
    endfunction

    function automatic bit m_wr(int i);
        return cfg_valid && m_ready() && (int'(cfg_ch) == i);
    endfunction

    function automatic logic [NCH-1:0] m_tick_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_n[i] != 0) && (m_cnt[i] == m_n[i] - 1);
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_div_vec();
        logic [NCH-1:0] v;
        logic [NCH-1:0] t;
        t = m_tick_vec();
        for (int i = 0; i < NCH; i++) begin
            if (m_n[i] == 0)  v[i] = 1'b0;
            else if (m_sq[i]) v[i] = (m_cnt[i] < (m_n[i] + 1) / 2);
            else              v[i] = t[i];
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_n[i] <= 0; m_cnt[i] <= 0; m_pn[i] <= 0;
                m_sq[i] <= 0; m_psq[i] <= 0; m_pv[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync || m_n[i] == 0 || m_cnt[i] == m_n[i] - 1) begin
                    m_cnt[i] <= 0;
                    m_pv[i]  <= 0;
                    if (m_wr(i)) begin
                        m_n[i] <= cfg_div; m_sq[i] <= cfg_mode;
                    end else if (m_pv[i]) begin
                        m_n[i] <= m_pn[i]; m_sq[i] <= m_psq[i];
                    end
                end else begin
                    m_cnt[i] <= m_cnt[i] + 1;
                    if (m_wr(i)) begin
                        m_pn[i] <= cfg_div; m_psq[i] <= cfg_mode; m_pv[i] <= 1;
                    end
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input bit v, input logic [1:0] ch, input int unsigned d, input bit m);
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_div   = DIV_W'(d);
        cfg_mode  = m;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync = 1'b0;
        set_cfg(0, 2'd0, 0, 0);
        repeat (3) @(negedge clk);
        total++; if (div_o !== 3'b000) begin bad++; $display("FAIL reset_div: got %b want 000", div_o); end
        total++; if (tick_o !== 3'b000) begin bad++; $display("FAIL reset_tick: got %b want 000", tick_o); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        rst = 1'b0;
        next_cyc();
        total++; if (div_o !== 3'b000) begin bad++; $display("FAIL reset_stopped: got %b want 000", div_o); end
    endtask

    task automatic test_strobe();
        bit e;
        set_cfg(1, 2'd0, 12, 0);
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL strobe_ready: got %b want 1", cfg_ready); end
        next_cyc();
        set_cfg(0, 2'd0, 0, 0);
        for (int k = 1; k <= 36; k++) begin
            e = (k % 12 == 0);
            total++; if (tick_o !== {2'b00, e}) begin bad++; $display("FAIL strobe_tick k=%0d: got %b want %b", k, tick_o, {2'b00, e}); end
            total++; if (div_o !== {2'b00, e}) begin bad++; $display("FAIL strobe_div k=%0d: got %b want %b", k, div_o, {2'b00, e}); end
            next_cyc();
        end
    endtask

    task automatic test_square();
        int unsigned c;
        set_cfg(1, 2'd1, 5, 1);
        next_cyc();
        set_cfg(0, 2'd0, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            c = (k - 1) % 5;
            total++; if (div_o[1] !== (c < 3)) begin bad++; $display("FAIL square_div k=%0d: got %b want %b", k, div_o[1], (c < 3)); end
            total++; if (tick_o[1] !== (c == 4)) begin bad++; $display("FAIL square_tick k=%0d: got %b want %b", k, tick_o[1], (c == 4)); end
            total++; if (div_o !== m_div_vec()) begin bad++; $display("FAIL square_model k=%0d: got %b want %b", k, div_o, m_div_vec()); end
            next_cyc();
        end
    endtask

    task automatic test_reprogram();
        bit er, et;
        for (int g = 0; g < 20 && m_cnt[0] != 3; g++) next_cyc();
        set_cfg(1, 2'd0, 4, 0);
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reprog_ready0: got %b want 1", cfg_ready); end
        next_cyc();
        set_cfg(1, 2'd0, 9, 0);
        for (int k = 1; k <= 22; k++) begin
            #1;
            er = (k == 9) || (k >= 13);
            et = (k == 8) || (k == 12) || (k == 21);
            total++; if (cfg_ready !== er) begin bad++; $display("FAIL reprog_ready k=%0d: got %b want %b", k, cfg_ready, er); end
            total++; if (tick_o[0] !== et) begin bad++; $display("FAIL reprog_tick k=%0d: got %b want %b", k, tick_o[0], et); end
            total++; if (div_o[0] !== et) begin bad++; $display("FAIL reprog_div k=%0d: got %b want %b", k, div_o[0], et); end
            next_cyc();
            if (k == 9) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_tc_write();
        for (int g = 0; g < 20 && m_cnt[0] != m_n[0] - 1; g++) next_cyc();
        total++; if (tick_o[0] !== 1'b1) begin bad++; $display("FAIL tc_tick: got %b want 1", tick_o[0]); end
        set_cfg(1, 2'd0, 6, 0);
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL tc_ready0: got %b want 1", cfg_ready); end
        next_cyc();
        set_cfg(0, 2'd0, 0, 0);
        for (int k = 1; k <= 13; k++) begin
            #1;
            total++; if (tick_o[0] !== (k % 6 == 0)) begin bad++; $display("FAIL tc_period k=%0d: got %b want %b", k, tick_o[0], (k % 6 == 0)); end
            total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL tc_ready k=%0d: got %b want 1", k, cfg_ready); end
            next_cyc();
        end
    endtask

    task automatic test_sync();
        set_cfg(1, 2'd0, 7, 0);
        next_cyc();
        set_cfg(1, 2'd2, 3, 0);
        next_cyc();
        set_cfg(0, 2'd0, 0, 0);
        repeat (8) next_cyc();
        for (int g = 0; g < 25 && !(m_cnt[0] >= 1 && m_cnt[0] <= 5 && m_cnt[2] != 2); g++) next_cyc();
        sync = 1'b1;
        total++; if (tick_o !== 3'b000 && (tick_o & 3'b101) !== 3'b000) begin bad++; $display("FAIL sync_cycle_tick: got %b want x0x0", tick_o); end
        next_cyc();
        sync = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            total++; if (tick_o[0] !== (k % 7 == 0)) begin bad++; $display("FAIL sync_tick0 k=%0d: got %b want %b", k, tick_o[0], (k % 7 == 0)); end
            total++; if (tick_o[2] !== (k % 3 == 0)) begin bad++; $display("FAIL sync_tick2 k=%0d: got %b want %b", k, tick_o[2], (k % 3 == 0)); end
            next_cyc();
        end
    endtask

    task automatic test_random();
        int unsigned d;
        for (int k = 0; k < 400; k++) begin
            total++; if (div_o !== m_div_vec()) begin bad++; $display("FAIL rand_div k=%0d: got %b want %b", k, div_o, m_div_vec()); end
            total++; if (tick_o !== m_tick_vec()) begin bad++; $display("FAIL rand_tick k=%0d: got %b want %b", k, tick_o, m_tick_vec()); end
            d = ($urandom % 5 == 0) ? $urandom_range(0, 511) : $urandom_range(0, 8);
            set_cfg(($urandom % 8) < 3, 2'($urandom_range(0, 3)), d, $urandom % 2);
            sync = ($urandom % 25 == 0);
            #1;
            total++; if (cfg_ready !== m_ready()) begin bad++; $display("FAIL rand_ready k=%0d: got %b want %b", k, cfg_ready, m_ready()); end
            next_cyc();
        end
        set_cfg(0, 2'd0, 0, 0);
        sync = 1'b0;
    endtask

    task automatic test_reset_mid();
        sync = 1'b1;
        next_cyc();
        set_cfg(1, 2'd0, 10, 0);
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_sync_ready0: got %b want 1", cfg_ready); end
        next_cyc();
        set_cfg(1, 2'd1, 1, 1);
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_sync_ready1: got %b want 1", cfg_ready); end
        next_cyc();
        sync = 1'b0;
        set_cfg(0, 2'd0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            #1;
            total++; if (tick_o[0] !== (k == 10)) begin bad++; $display("FAIL rmid_tick0 k=%0d: got %b want %b", k, tick_o[0], (k == 10)); end
            total++; if (div_o[1] !== 1'b1 || tick_o[1] !== 1'b1) begin bad++; $display("FAIL rmid_n1 k=%0d: got div=%b tick=%b want 1 1", k, div_o[1], tick_o[1]); end
            total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready k=%0d: got %b want 1", k, cfg_ready); end
            next_cyc();
        end
        set_cfg(1, 2'd0, 4, 0);
        next_cyc();
        cfg_valid = 1'b0;
        #1;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rmid_pending: got %b want 0", cfg_ready); end
        total++; if (div_o[1] !== 1'b1) begin bad++; $display("FAIL rmid_pre: got %b want 1", div_o[1]); end
        #2 rst = 1'b1;
        #1;
        total++; if (div_o !== 3'b000) begin bad++; $display("FAIL rmid_async_div: got %b want 000", div_o); end
        total++; if (tick_o !== 3'b000) begin bad++; $display("FAIL rmid_async_tick: got %b want 000", tick_o); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_async_ready: got %b want 1", cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            total++; if (div_o !== 3'b000 || tick_o !== 3'b000) begin bad++; $display("FAIL rmid_after k=%0d: got div=%b tick=%b want 000 000", k, div_o, tick_o); end
            total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_after_ready k=%0d: got %b want 1", k, cfg_ready); end
            next_cyc();
        end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_square();
        test_reprogram();
        test_tc_write();
        test_sync();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
